// File: rtl/register_writeback_pkg.sv
// Shared types and constants for the register bank write-back front end.
// Optional flush support is enabled by defining REGWB_FLUSH_EN.
package reg_wb_pkg;

  // Register bank geometry: 8 registers of 16 bits.
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // One queued write-back: destination register and the value to write.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot decode of a register index, used to build the pending mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/register_writeback_if.sv
// Producer-side write-back channel (ALU or memory stage).
// Handshake: a result transfers at a rising edge where valid and ready are
// both high; the producer holds rd/data stable while valid is high, and
// ready is a pure function of queue occupancy (and of mem valid for the ALU).
interface reg_wb_prod_if;
  logic                           valid;
  logic                           ready;
  logic [reg_wb_pkg::ADDR_W-1:0] rd;
  logic [reg_wb_pkg::DATA_W-1:0] data;

  // Producer drives the payload, the queue answers with ready.
  modport master (output valid, output rd, output data, input ready);
  modport slave  (input valid, input rd, input data, output ready);
endinterface

// File: rtl/register_writeback_fifo.sv
// In-order circular buffer of write-back entries. Accepts up to two pushes
// per cycle (push0 lands first) and at most one pop. The entry array and a
// per-slot valid mask are exported so the owner can build a pending mask.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push0_i,
  input  wb_entry_t              push0_entry_i,
  input  logic                   push1_i,
  input  wb_entry_t              push1_entry_i,
  input  logic                   pop_i,
  output wb_entry_t              head_o,
  output wb_entry_t [DEPTH-1:0]  entries_o,
  output logic      [DEPTH-1:0]  valid_o,
  output logic      [CNT_W-1:0]  count_o
);

  wb_entry_t [DEPTH-1:0] mem_q;
  wb_entry_t [DEPTH-1:0] mem_d;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_nx;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [CNT_W-1:0]      n_push;
  logic                  pop_eff;

  // Next-state for storage, pointers and occupancy; clear wins over traffic.
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wr_ptr_nx = wr_ptr_q + PTR_W'(1);
    pop_eff   = pop_i && (count_q != '0);
    n_push    = CNT_W'(push0_i) + CNT_W'(push1_i);

    // A lone push always takes the write slot; with two, push1 goes behind.
    if (push0_i) begin
      mem_d[wr_ptr_q] = push0_entry_i;
    end else if (push1_i) begin
      mem_d[wr_ptr_q] = push1_entry_i;
    end
    if (push0_i && push1_i) begin
      mem_d[wr_ptr_nx] = push1_entry_i;
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + n_push - CNT_W'(pop_eff);

    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents only matter for slots covered by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset  = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset     = PTR_W'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, offset} < count_q);
    end
  end

  assign head_o    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign entries_o = mem_q;
  assign count_o   = count_q;

endmodule

// File: rtl/register_writeback.sv
// Write-side front end of the 8x16 register bank. Merges ALU and memory
// write-back results into an in-order queue (memory first when both fire)
// and drains one entry per cycle onto the bank write port. Also exports a
// per-register pending mask for issue stalls.
// Define REGWB_FLUSH_EN to add a synchronous flush input.
module register_writeback
  import reg_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef REGWB_FLUSH_EN
  input  logic                flush,
`endif
  reg_wb_prod_if.slave        alu,
  reg_wb_prod_if.slave        mem,
  output logic [ADDR_W-1:0]   rd,
  output logic [DATA_W-1:0]   Datain,
  output logic                registerLoad,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    count
);

  localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_C = CNT_W'(DEPTH - 1);

  logic                  flush_w;
  logic                  mem_ready_w;
  logic                  alu_ready_w;
  logic                  mem_fire;
  logic                  alu_fire;
  wb_entry_t             mem_entry;
  wb_entry_t             alu_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic      [DEPTH-1:0] entry_valid;
  logic      [CNT_W-1:0] occ;

`ifdef REGWB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Ready from pre-edge occupancy only; a same-cycle pop earns no credit.
  // The ALU needs two free slots when memory is also offering.
  always_comb begin
    mem_ready_w = (occ < FULL_C) && !flush_w;
    alu_ready_w = ((occ < ALMOST_C) || ((occ < FULL_C) && !mem.valid)) && !flush_w;
  end

  assign mem.ready = mem_ready_w;
  assign alu.ready = alu_ready_w;
  assign mem_fire  = mem.valid && mem_ready_w;
  assign alu_fire  = alu.valid && alu_ready_w;

  assign mem_entry = '{rd: mem.rd, data: mem.data};
  assign alu_entry = '{rd: alu.rd, data: alu.data};

  // Memory is push0 so it drains ahead of a same-cycle ALU result.
  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (flush_w),
    .push0_i       (mem_fire),
    .push0_entry_i (mem_entry),
    .push1_i       (alu_fire),
    .push1_entry_i (alu_entry),
    .pop_i         (registerLoad),
    .head_o        (head),
    .entries_o     (entries),
    .valid_o       (entry_valid),
    .count_o       (occ)
  );

  // OR together the one-hot destination of every live queue entry.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending = pending | reg_onehot(entries[i].rd);
      end
    end
  end

  // The bank never stalls, so a non-empty queue writes its head every cycle.
  assign registerLoad = (occ != '0);
  assign rd           = head.rd;
  assign Datain       = head.data;
  assign count        = occ;

  // Occupancy can never exceed the queue depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ <= FULL_C);
    end
  end

endmodule

// File: tb/tb_register_writeback.sv
// Bench for register_writeback: a table of directed cycles with hand-derived
// occupancy and ready values, a random phase, and a scoreboard queue holding
// the entries the bank should receive, in order.
module tb_register_writeback;
  import reg_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = ADDR_W + DATA_W;

  logic                clk;
  logic                rst;
`ifdef REGWB_FLUSH_EN
  logic                flush;
`endif
  logic [ADDR_W-1:0]   rd;
  logic [DATA_W-1:0]   Datain;
  logic                registerLoad;
  logic [NUM_REGS-1:0] pending;
  logic [2:0]          count;

  reg_wb_prod_if alu_if ();
  reg_wb_prod_if mem_if ();

  register_writeback #(
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef REGWB_FLUSH_EN
    .flush        (flush),
`endif
    .alu          (alu_if),
    .mem          (mem_if),
    .rd           (rd),
    .Datain       (Datain),
    .registerLoad (registerLoad),
    .pending      (pending),
    .count        (count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic              mv;
    logic [ADDR_W-1:0] mrd;
    logic [DATA_W-1:0] md;
    logic              av;
    logic [ADDR_W-1:0] ard;
    logic [DATA_W-1:0] ad;
    logic              rs;
    logic              fl;
    logic [2:0]        e_cnt;
    logic              e_mr;
    logic              e_ar;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic mv, input logic [ADDR_W-1:0] mrd,
                              input logic [DATA_W-1:0] md, input logic av,
                              input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                              input logic rs, input logic fl, input logic [2:0] ec,
                              input logic emr, input logic ear);
    vec_t v;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.av = av; v.ard = ard; v.ad = ad;
    v.rs = rs; v.fl = fl;
    v.e_cnt = ec; v.e_mr = emr; v.e_ar = ear;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, check outputs against the model,
  // update the model for this edge, then advance to the next falling edge.
  task automatic run_cycle(input vec_t v, input bit use_tbl);
    int           sz;
    logic         emr;
    logic         ear;
    logic [7:0]   ep;
    logic [W-1:0] head;
    mem_if.valid = v.mv;
    mem_if.rd    = v.mrd;
    mem_if.data  = v.md;
    alu_if.valid = v.av;
    alu_if.rd    = v.ard;
    alu_if.data  = v.ad;
    rst          = v.rs;
`ifdef REGWB_FLUSH_EN
    flush        = v.fl;
`endif
    #1;
    sz  = exp_q.size();
    emr = (sz < DEPTH) && !v.fl;
    ear = ((sz < DEPTH - 1) || ((sz < DEPTH) && !v.mv)) && !v.fl;
    ep  = '0;
    foreach (exp_q[i]) ep[exp_q[i][W-1:DATA_W]] = 1'b1;

    check("mem_ready", 32'(mem_if.ready), 32'(emr));
    check("alu_ready", 32'(alu_if.ready), 32'(ear));
    check("count", 32'(count), 32'(sz));
    check("registerLoad", 32'(registerLoad), 32'(sz != 0));
    check("pending", 32'(pending), 32'(ep));
    if (sz != 0) begin
      head = exp_q.pop_front();
      check("rd", 32'(rd), 32'(head[W-1:DATA_W]));
      check("Datain", 32'(Datain), 32'(head[DATA_W-1:0]));
    end else begin
      check("rd_idle", 32'(rd), 32'd0);
      check("Datain_idle", 32'(Datain), 32'd0);
    end
    if (use_tbl) begin
      check("tbl_count", 32'(count), 32'(v.e_cnt));
      check("tbl_mem_ready", 32'(mem_if.ready), 32'(v.e_mr));
      check("tbl_alu_ready", 32'(alu_if.ready), 32'(v.e_ar));
    end

    if (v.rs || v.fl) begin
      exp_q.delete();
    end else begin
      if (v.mv && emr) exp_q.push_back({v.mrd, v.md});
      if (v.av && ear) exp_q.push_back({v.ard, v.ad});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t idle;
    vec_t rv;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Reset held for two edges.
    rst          = 1'b1;
    mem_if.valid = 1'b0; mem_if.rd = '0; mem_if.data = '0;
    alu_if.valid = 1'b0; alu_if.rd = '0; alu_if.data = '0;
`ifdef REGWB_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_registerLoad", 32'(registerLoad), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_mem_ready", 32'(mem_if.ready), 32'd1);
    check("rst_alu_ready", 32'(alu_if.ready), 32'd1);

    // Directed cycles: {mem, alu, rst, flush} stimulus and pre-edge count/readies.
    tbl[0]  = mk(0, 0, 16'h0000, 1, 3, 16'hBEEF, 0, 0, 3'd0, 1, 1);
    tbl[1]  = idle; tbl[1].e_cnt = 3'd1;
    tbl[2]  = idle;
    tbl[3]  = mk(1, 1, 16'h1111, 1, 1, 16'h2222, 0, 0, 3'd0, 1, 1);
    tbl[4]  = idle; tbl[4].e_cnt = 3'd2;
    tbl[5]  = idle; tbl[5].e_cnt = 3'd1;
    tbl[6]  = idle;
    tbl[7]  = mk(1, 2, 16'hA001, 1, 4, 16'hA002, 0, 0, 3'd0, 1, 1);
    tbl[8]  = mk(1, 5, 16'hA003, 1, 6, 16'hA004, 0, 0, 3'd2, 1, 1);
    tbl[9]  = mk(1, 7, 16'hA005, 1, 0, 16'hA006, 0, 0, 3'd3, 1, 0);
    tbl[10] = mk(0, 0, 16'h0000, 1, 0, 16'hA006, 0, 0, 3'd3, 1, 1);
    tbl[11] = mk(1, 1, 16'hA007, 1, 2, 16'hA008, 1, 0, 3'd3, 1, 0);
    tbl[12] = idle;
    for (int i = 0; i < 13; i++) begin
      run_cycle(tbl[i], 1'b1);
    end

    // Random traffic from both producers.
    for (int i = 0; i < 120; i++) begin
      rv = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
              1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      run_cycle(rv, 1'b0);
    end

    // Bounded drain; every accepted entry must have reached the bank.
    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) begin
      run_cycle(idle, 1'b0);
    end
    check("drain_model_empty", 32'(exp_q.size()), 32'd0);
    check("drain_count", 32'(count), 32'd0);

`ifdef REGWB_FLUSH_EN
    // Flush with two entries queued and memory offering.
    run_cycle(mk(1, 4, 16'hC001, 1, 5, 16'hC002, 0, 0, 3'd0, 1, 1), 1'b1);
    run_cycle(mk(1, 6, 16'hC003, 0, 0, 16'h0000, 0, 1, 3'd2, 0, 0), 1'b1);
    run_cycle(idle, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
